pc_prefetch: RTL and testbench

- Parametrised instruction-fetch front end for the RISC-V core.
- Owns the program counter and issues word fetch requests to the memory controller with a valid/ready handshake, one outstanding request at a time.
- Buffers returned instructions with their PCs in a DEPTH-entry FIFO feeding decode.
- Handles jump redirects by flushing the FIFO and discarding any in-flight response.

---
 rtl/pc_prefetch.sv | 137 +++++++++++++
 tb/tb_pc_prefetch.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_prefetch.sv
// Instruction-fetch front end: owns the PC, issues one word fetch at a time and
// queues returned instructions with their PCs in a small FIFO feeding decode.
module pc_prefetch #(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int unsigned     INC      = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic                       req_o,
    output logic [XLEN-1:0]            req_addr_o,
    input  logic                       req_ready_i,
    input  logic                       resp_valid_i,
    input  logic [XLEN-1:0]            resp_data_i,
    input  logic                       jump_i,
    input  logic [XLEN-1:0]            jump_pc_i,
    output logic                       inst_valid_o,
    output logic [XLEN-1:0]            inst_o,
    output logic [XLEN-1:0]            inst_pc_o,
    input  logic                       stall_i,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        DISCARD = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [XLEN-1:0]    pc_q, pc_d;
    logic [XLEN-1:0]    req_pc_q, req_pc_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;

    logic [XLEN-1:0]    inst_mem_q [DEPTH];
    logic [XLEN-1:0]    pc_mem_q   [DEPTH];

    logic               full;
    logic               accept;
    logic               push;
    logic               pop;
    logic [XLEN-1:0]    jump_target;
    logic               jump_lsb_unused;

    assign jump_target     = {jump_pc_i[XLEN-1:2], 2'b00};
    assign jump_lsb_unused = ^jump_pc_i[1:0];

    // Space is reserved at issue time, so a response can always be pushed.
    assign full   = (count_q == CNT_W'(DEPTH));
    assign req_o  = (state_q == IDLE) && !full && !jump_i && !rst;
    assign accept = req_o && req_ready_i;
    assign push   = (state_q == WAIT) && resp_valid_i && !jump_i;
    assign pop    = inst_valid_o && !stall_i && !jump_i;

    assign req_addr_o   = pc_q;
    assign count_o      = count_q;
    assign inst_valid_o = (count_q != '0);
    assign inst_o       = inst_valid_o ? inst_mem_q[rd_ptr_q] : '0;
    assign inst_pc_o    = inst_valid_o ? pc_mem_q[rd_ptr_q]   : '0;

    always_comb begin
        pc_d     = pc_q;
        req_pc_d = req_pc_q;
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (accept) begin
            pc_d     = pc_q + XLEN'(INC);
            req_pc_d = pc_q;
        end
        if (jump_i) begin
            pc_d = jump_target;
        end

        case (state_q)
            IDLE: begin
                if (accept) state_d = WAIT;
            end
            WAIT: begin
                if (jump_i)            state_d = resp_valid_i ? IDLE : DISCARD;
                else if (resp_valid_i) state_d = IDLE;
            end
            DISCARD: begin
                if (resp_valid_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // A redirect empties the queue and overrides any push or pop this cycle.
        if (jump_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            pc_q     <= RESET_PC;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        req_pc_q <= req_pc_d;
        if (push) begin
            inst_mem_q[wr_ptr_q] <= resp_data_i;
            pc_mem_q[wr_ptr_q]   <= req_pc_q;
        end
    end

endmodule

// File: tb/tb_pc_prefetch.sv
// Bench for pc_prefetch: a memory-controller model answers accepted requests and a
// scoreboard of expected {pc, instruction} pairs is checked against decode pops.
module tb_pc_prefetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_o;
    logic [31:0] req_addr_o;
    logic        req_ready_i;
    logic        resp_valid_i;
    logic [31:0] resp_data_i;
    logic        jump_i;
    logic [31:0] jump_pc_i;
    logic        inst_valid_o;
    logic [31:0] inst_o;
    logic [31:0] inst_pc_o;
    logic        stall_i;
    logic [2:0]  count_o;

    logic        w_req_o;
    logic [31:0] w_req_addr_o;
    logic        w_req_ready_i;
    logic        w_resp_valid_i;
    logic [31:0] w_resp_data_i;
    logic        w_inst_valid_o;
    logic [31:0] w_inst_o;
    logic [31:0] w_inst_pc_o;
    logic [2:0]  w_count_o;

    always #5 clk = ~clk;

    pc_prefetch #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0), .INC(4)) dut (
        .clk(clk), .rst(rst), .req_o(req_o), .req_addr_o(req_addr_o),
        .req_ready_i(req_ready_i), .resp_valid_i(resp_valid_i), .resp_data_i(resp_data_i),
        .jump_i(jump_i), .jump_pc_i(jump_pc_i), .inst_valid_o(inst_valid_o),
        .inst_o(inst_o), .inst_pc_o(inst_pc_o), .stall_i(stall_i), .count_o(count_o)
    );

    pc_prefetch #(.XLEN(32), .DEPTH(4), .RESET_PC(32'hFFFF_FFFC), .INC(4)) u_wrap (
        .clk(clk), .rst(rst), .req_o(w_req_o), .req_addr_o(w_req_addr_o),
        .req_ready_i(w_req_ready_i), .resp_valid_i(w_resp_valid_i), .resp_data_i(w_resp_data_i),
        .jump_i(1'b0), .jump_pc_i(32'h0), .inst_valid_o(w_inst_valid_o),
        .inst_o(w_inst_o), .inst_pc_o(w_inst_pc_o), .stall_i(1'b1), .count_o(w_count_o)
    );

    int          checks = 0;
    int          errors = 0;
    bit          pending;
    bit          drop_pending;
    int          pend_cnt;
    int          mem_lat;
    logic [31:0] pend_addr;
    logic [31:0] issued [$];
    logic [63:0] exp_q [$];
    int          n_pops;
    logic [31:0] last_pop_pc;
    logic        obs_req;
    logic [31:0] obs_addr;

    function automatic logic [31:0] data_of(input logic [31:0] a);
        return (a << 5) + 32'h13;
    endfunction

    // One clock cycle: memory model drives its response, handshakes are observed
    // before the rising edge, and the call returns at the following falling edge.
    task automatic tick();
        logic [63:0] e;
        resp_valid_i = 1'b0;
        resp_data_i  = '0;
        if (pending && pend_cnt == 0) begin
            resp_valid_i = 1'b1;
            resp_data_i  = data_of(pend_addr);
        end
        #1;
        obs_req  = req_o;
        obs_addr = req_addr_o;
        if (!rst && inst_valid_o === 1'b1 && !stall_i && !jump_i) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL pop_unexpected: got pc=%h inst=%h, required no valid entry", inst_pc_o, inst_o);
            end else begin
                e = exp_q.pop_front();
                if ({inst_pc_o, inst_o} !== e) begin
                    errors++;
                    $display("FAIL pop_data: got pc=%h inst=%h, required pc=%h inst=%h",
                             inst_pc_o, inst_o, e[63:32], e[31:0]);
                end
            end
            n_pops++;
            last_pop_pc = inst_pc_o;
        end
        if (resp_valid_i) begin
            if (!drop_pending && !jump_i) exp_q.push_back({pend_addr, data_of(pend_addr)});
            pending      = 1'b0;
            drop_pending = 1'b0;
        end
        if (jump_i) begin
            exp_q.delete();
            if (pending) drop_pending = 1'b1;
        end
        if (req_o === 1'b1 && req_ready_i) begin
            pending   = 1'b1;
            pend_addr = req_addr_o;
            pend_cnt  = mem_lat - 1;
            issued.push_back(req_addr_o);
        end else if (pending && pend_cnt > 0) begin
            pend_cnt--;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        jump_i         = 1'b0;
        jump_pc_i      = '0;
        stall_i        = 1'b0;
        req_ready_i    = 1'b0;
        w_req_ready_i  = 1'b0;
        w_resp_valid_i = 1'b0;
        pending        = 1'b0;
        drop_pending   = 1'b0;
        mem_lat        = 1;
        exp_q.delete();
        issued.delete();
        n_pops = 0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        rst = 1'b1;
        tick();
        checks++;
        if (count_o !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d, required 0", count_o); end
        checks++;
        if (inst_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b, required 0", inst_valid_o); end
        checks++;
        if (inst_o !== 32'h0) begin errors++; $display("FAIL reset_inst: got %h, required 0", inst_o); end
        checks++;
        if (inst_pc_o !== 32'h0) begin errors++; $display("FAIL reset_inst_pc: got %h, required 0", inst_pc_o); end
        checks++;
        if (obs_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b, required 0", obs_req); end
        rst = 1'b0;
    endtask

    task automatic test_sequence();
        do_reset();
        req_ready_i = 1'b1;
        mem_lat     = 1;
        tick();
        checks++;
        if (obs_req !== 1'b1 || obs_addr !== 32'h0) begin
            errors++;
            $display("FAIL first_req: got req=%b addr=%h, required req=1 addr=00000000", obs_req, obs_addr);
        end
        repeat (9) tick();
        checks++;
        if (issued.size() < 3) begin
            errors++;
            $display("FAIL seq_issue_count: got %0d, required at least 3", issued.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (issued[i] !== 32'(i * 4)) begin
                    errors++;
                    $display("FAIL seq_addr%0d: got %h, required %h", i, issued[i], 32'(i * 4));
                end
            end
        end
        checks++;
        if (n_pops < 3) begin errors++; $display("FAIL seq_pops: got %0d, required at least 3", n_pops); end
    endtask

    task automatic test_stall();
        do_reset();
        req_ready_i = 1'b1;
        stall_i     = 1'b1;
        mem_lat     = 1;
        repeat (12) tick();
        checks++;
        if (obs_req !== 1'b0) begin errors++; $display("FAIL full_req: got %b, required 0", obs_req); end
        checks++;
        if (count_o !== 3'd4) begin errors++; $display("FAIL full_count: got %0d, required 4", count_o); end
        checks++;
        if (issued.size() != 4) begin errors++; $display("FAIL full_issues: got %0d, required 4", issued.size()); end
        stall_i = 1'b0;
        tick();
        stall_i = 1'b1;
        tick();
        checks++;
        if (obs_req !== 1'b1 || obs_addr !== 32'h10) begin
            errors++;
            $display("FAIL refill_req: got req=%b addr=%h, required req=1 addr=00000010", obs_req, obs_addr);
        end
        checks++;
        if (count_o !== 3'd3) begin errors++; $display("FAIL refill_count: got %0d, required 3", count_o); end
        checks++;
        if (issued.size() != 5) begin errors++; $display("FAIL refill_issues: got %0d, required 5", issued.size()); end
    endtask

    task automatic test_jump_wait();
        int pops0;
        do_reset();
        req_ready_i = 1'b1;
        mem_lat     = 4;
        for (int i = 0; i < 60 && issued.size() < 3; i++) tick();
        checks++;
        if (issued.size() < 3 || issued[2] !== 32'h8) begin
            errors++;
            $display("FAIL jw_issue_8: got %0d issues, required third request to 00000008", issued.size());
        end
        tick();
        jump_i    = 1'b1;
        jump_pc_i = 32'h103;
        tick();
        jump_i  = 1'b0;
        mem_lat = 1;
        checks++;
        if (count_o !== 3'd0) begin errors++; $display("FAIL jw_flush: got %0d, required 0", count_o); end
        for (int i = 0; i < 20 && pending; i++) tick();
        checks++;
        if (count_o !== 3'd0 || inst_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL jw_drop: got count=%0d valid=%b, required 0/0", count_o, inst_valid_o);
        end
        for (int i = 0; i < 10 && issued.size() < 4; i++) tick();
        checks++;
        if (issued.size() < 4 || issued[3] !== 32'h100) begin
            errors++;
            $display("FAIL jw_target_req: got %0d issues last=%h, required 00000100", issued.size(),
                     issued.size() > 0 ? issued[issued.size() - 1] : 32'h0);
        end
        pops0 = n_pops;
        for (int i = 0; i < 10 && n_pops == pops0; i++) tick();
        checks++;
        if (n_pops == pops0 || last_pop_pc !== 32'h100) begin
            errors++;
            $display("FAIL jw_first_pc: got pops=%0d pc=%h, required pc 00000100", n_pops - pops0, last_pop_pc);
        end
    endtask

    task automatic test_jump_resp_pop();
        do_reset();
        req_ready_i = 1'b1;
        stall_i     = 1'b1;
        mem_lat     = 1;
        repeat (3) tick();
        checks++;
        if (count_o !== 3'd1 || !pending) begin
            errors++;
            $display("FAIL jr_setup: got count=%0d pending=%b, required 1/1", count_o, pending);
        end
        stall_i   = 1'b0;
        jump_i    = 1'b1;
        jump_pc_i = 32'h200;
        tick();
        jump_i  = 1'b0;
        stall_i = 1'b1;
        checks++;
        if (count_o !== 3'd0 || inst_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL jr_empty: got count=%0d valid=%b, required 0/0", count_o, inst_valid_o);
        end
        tick();
        checks++;
        if (obs_req !== 1'b1 || obs_addr !== 32'h200) begin
            errors++;
            $display("FAIL jr_target_req: got req=%b addr=%h, required req=1 addr=00000200", obs_req, obs_addr);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        w_req_ready_i = 1'b1;
        #1;
        checks++;
        if (w_req_o !== 1'b1 || w_req_addr_o !== 32'hFFFF_FFFC) begin
            errors++;
            $display("FAIL wrap_first: got req=%b addr=%h, required req=1 addr=fffffffc", w_req_o, w_req_addr_o);
        end
        tick();
        w_req_ready_i  = 1'b0;
        w_resp_valid_i = 1'b1;
        w_resp_data_i  = 32'h13;
        tick();
        w_resp_valid_i = 1'b0;
        w_req_ready_i  = 1'b1;
        #1;
        checks++;
        if (w_req_o !== 1'b1 || w_req_addr_o !== 32'h0) begin
            errors++;
            $display("FAIL wrap_second: got req=%b addr=%h, required req=1 addr=00000000", w_req_o, w_req_addr_o);
        end
        checks++;
        if (w_count_o !== 3'd1 || w_inst_pc_o !== 32'hFFFF_FFFC || w_inst_o !== 32'h13) begin
            errors++;
            $display("FAIL wrap_head: got count=%0d pc=%h inst=%h, required 1/fffffffc/00000013",
                     w_count_o, w_inst_pc_o, w_inst_o);
        end
        tick();
        w_req_ready_i = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        req_ready_i = 1'b1;
        stall_i     = 1'b1;
        mem_lat     = 1;
        for (int i = 0; i < 20 && issued.size() < 4; i++) tick();
        checks++;
        if (count_o !== 3'd3 || !pending) begin
            errors++;
            $display("FAIL rm_setup: got count=%0d pending=%b, required 3/1", count_o, pending);
        end
        rst          = 1'b1;
        pending      = 1'b0;
        drop_pending = 1'b0;
        exp_q.delete();
        tick();
        checks++;
        if (count_o !== 3'd0 || inst_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL rm_flush: got count=%0d valid=%b, required 0/0", count_o, inst_valid_o);
        end
        checks++;
        if (obs_req !== 1'b0) begin errors++; $display("FAIL rm_req_in_reset: got %b, required 0", obs_req); end
        rst = 1'b0;
        tick();
        checks++;
        if (obs_req !== 1'b1 || obs_addr !== 32'h0) begin
            errors++;
            $display("FAIL rm_restart: got req=%b addr=%h, required req=1 addr=00000000", obs_req, obs_addr);
        end
    endtask

    initial begin
        rst            = 1'b1;
        req_ready_i    = 1'b0;
        resp_valid_i   = 1'b0;
        resp_data_i    = '0;
        jump_i         = 1'b0;
        jump_pc_i      = '0;
        stall_i        = 1'b0;
        w_req_ready_i  = 1'b0;
        w_resp_valid_i = 1'b0;
        w_resp_data_i  = '0;
        mem_lat        = 1;
        n_pops         = 0;
        last_pop_pc    = '0;
        @(negedge clk);
        test_reset();
        test_sequence();
        test_stall();
        test_jump_wait();
        test_jump_resp_pop();
        test_wrap();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at time limit, required completion");
        $fatal(1);
    end

endmodule
